// File: rtl/spart_pkg.sv
// SPART shared definitions: state encoding, register map, framing defaults.
// Imported by both the transmit and receive paths.
package spart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_W_DEF     = 8;

  localparam logic [1:0] ADDR_DATA = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } tx_state_t;

endpackage

// File: rtl/spart_transmit_if.sv
// SPART transmit bus bundle: processor-side strobes, baud tick and
// serial/status outputs.
interface spart_transmit_if
  import spart_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              Enable;
  logic              iocs;
  logic              IORW;
  logic [1:0]        IOADDR;
  logic [DATA_W-1:0] DATA_IN;
  logic              TxD;
  logic              TBR;
  logic              TX_BUSY;

  modport master (
    output Enable, iocs, IORW, IOADDR, DATA_IN,
    input  TxD, TBR, TX_BUSY
  );

  modport slave (
    input  Enable, iocs, IORW, IOADDR, DATA_IN,
    output TxD, TBR, TX_BUSY
  );

endinterface

// File: rtl/spart_tx_shift.sv
// SPART transmit datapath: holding register, shift register, TBR flag.
// A load always wins over a write, so a coincident write sees TBR=0.
module spart_tx_shift #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              load,
  input  logic              shift_en,
  output logic              tbr,
  output logic              full,
  output logic              lsb,
  output logic              nxt
);

  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] shreg_q;
  logic              tbr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q  <= '0;
      shreg_q <= '0;
      tbr_q   <= 1'b1;
    end else begin
      if (load) begin
        shreg_q <= hold_q;
        tbr_q   <= 1'b1;
      end else if (wr_en && tbr_q) begin
        hold_q <= wr_data;
        tbr_q  <= 1'b0;
      end
      if (shift_en) begin
        shreg_q <= shreg_q >> 1;
      end
    end
  end

  assign tbr  = tbr_q;
  assign full = ~tbr_q;
  assign lsb  = shreg_q[0];
  assign nxt  = shreg_q[1];

endmodule

// File: rtl/spart_transmit.sv
// SPART transmit path: 8N1 serialiser timed by the shared 16x baud tick.
// FSM and counters live here; data registers live in spart_tx_shift.
module spart_transmit
  import spart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  spart_transmit_if.slave bus
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);

  tx_state_t     state_q;
  logic [TW-1:0] tick_q;
  logic [BW-1:0] bcnt_q;
  logic          txd_q;
  logic          busy_q;

  logic wr_en;
  logic bit_end;
  logic load;
  logic shift_en;
  logic full;
  logic tbr;
  logic lsb;
  logic nxt;

  assign wr_en = bus.iocs && !bus.IORW
              && (bus.IOADDR == ADDR_DATA);

  assign bit_end  = bus.Enable && (tick_q == LAST_TICK);
  assign shift_en = (state_q == DATA) && bit_end;

  // Back-to-back frames reload on the stop bit's final tick.
  assign load = full && ((state_q == IDLE)
             || ((state_q == STOP) && bit_end));

  spart_tx_shift #(
    .DATA_W (DATA_W)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (bus.DATA_IN),
    .load     (load),
    .shift_en (shift_en),
    .tbr      (tbr),
    .full     (full),
    .lsb      (lsb),
    .nxt      (nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bcnt_q  <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else if (load) begin
      state_q <= START;
      tick_q  <= '0;
      txd_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else if ((state_q != IDLE) && bus.Enable) begin
      tick_q <= tick_q + TW'(1);
      if (bit_end) begin
        unique case (state_q)
          START: begin
            state_q <= DATA;
            bcnt_q  <= '0;
            txd_q   <= lsb;
          end
          DATA: begin
            if (bcnt_q == LAST_BIT) begin
              state_q <= STOP;
              txd_q   <= 1'b1;
            end else begin
              bcnt_q <= bcnt_q + BW'(1);
              txd_q  <= nxt;
            end
          end
          STOP: begin
            state_q <= IDLE;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.TxD     = txd_q;
  assign bus.TBR     = tbr;
  assign bus.TX_BUSY = busy_q;

endmodule
